addr4u_result_checker: RTL and testbench

- Registered checking stage directly downstream of the fault-resilient 4-bit unsigned adders (addr4u_*).
- Captures each operand pair together with the adder's 5-bit result and recomputes a golden sum.
- Flags, counts and optionally corrects mismatches, then forwards the result through a 2-entry skid buffer with a valid/ready handshake.
- Also runs a health state machine, so fault injection campaigns can measure observed p_fault and resilience at system level.

---
 rtl/addr4u_pkg.sv | 18 +
 rtl/addr4u_skid2.sv | 71 +++++++
 rtl/addr4u_result_checker.sv | 100 ++++++++++
 tb/tb_addr4u_result_checker.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/addr4u_pkg.sv
// Shared types and widths for the addr4u result-checking stage.
package addr4u_pkg;

    localparam int unsigned SUM_W  = 5;
    localparam int unsigned OPND_W = 4;

    typedef enum logic [1:0] {
        OK       = 2'd0,
        DEGRADED = 2'd1,
        FAILED   = 2'd2
    } health_t;

    typedef struct packed {
        logic [SUM_W-1:0] sum;
        logic             err;
    } entry_t;

endpackage

// File: rtl/addr4u_skid2.sv
// Two-entry FIFO-ordered valid/ready buffer; all outputs come straight from flops.
module addr4u_skid2
    import addr4u_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   push_valid,
    output logic   push_ready,
    input  entry_t push_data,
    output logic   pop_valid,
    input  logic   pop_ready,
    output entry_t pop_data
);

    logic [1:0] cnt_q, cnt_d;
    entry_t     head_q, head_d;
    entry_t     tail_q, tail_d;
    logic       ready_q, ready_d;
    logic       valid_q, valid_d;
    logic       push, pop;

    // Occupancy update; a push at occupancy 2 cannot happen because ready is low.
    always_comb begin
        push   = push_valid && ready_q;
        pop    = valid_q && pop_ready;
        cnt_d  = cnt_q;
        head_d = head_q;
        tail_d = tail_q;
        case ({push, pop})
            2'b10: begin
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd0) begin
                    head_d = push_data;
                end else begin
                    tail_d = push_data;
                end
            end
            2'b01: begin
                cnt_d = cnt_q - 2'd1;
                if (cnt_q == 2'd2) begin
                    head_d = tail_q;
                end
            end
            2'b11: head_d = push_data;
            default: ;
        endcase
        ready_d = (cnt_d != 2'd2);
        valid_d = (cnt_d != 2'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= 2'd0;
            head_q  <= '0;
            tail_q  <= '0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
        end
    end

    assign push_ready = ready_q;
    assign pop_valid  = valid_q;
    assign pop_data   = head_q;

endmodule

// File: rtl/addr4u_result_checker.sv
// Checks 4-bit adder results against a golden sum, counts/corrects faults,
// tracks health, and forwards results through a 2-entry skid buffer.
module addr4u_result_checker
    import addr4u_pkg::*;
#(
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned FAIL_THRESH = 4,
    parameter bit          CORRECT_EN  = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OPND_W-1:0] in_a,
    input  logic [OPND_W-1:0] in_b,
    input  logic [SUM_W-1:0]  in_sum,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [SUM_W-1:0]  out_sum,
    output logic              out_err,
    output logic [CNT_W-1:0]  err_cnt,
    output logic [CNT_W-1:0]  txn_cnt,
    output logic [1:0]        health,
    input  logic              clr_stats
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] THRESH  = CNT_W'(FAIL_THRESH);

    logic             accept;
    logic             mismatch;
    logic [SUM_W-1:0] golden;
    entry_t           entry;
    entry_t           head;
    logic [CNT_W-1:0] err_base, txn_base;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0] txn_cnt_q, txn_cnt_d;
    health_t          health_q, health_d;

    // Golden recompute and entry formation; mismatch is gated so idle inputs never matter.
    always_comb begin
        accept    = in_valid && in_ready;
        golden    = SUM_W'(in_a) + SUM_W'(in_b);
        mismatch  = accept && (in_sum != golden);
        entry.sum = (CORRECT_EN && mismatch) ? golden : in_sum;
        entry.err = mismatch;
    end

    // clr_stats wipes the baseline first, so a coinciding beat counts alone.
    always_comb begin
        err_base  = clr_stats ? '0 : err_cnt_q;
        txn_base  = clr_stats ? '0 : txn_cnt_q;
        health_d  = clr_stats ? OK : health_q;
        err_cnt_d = err_base;
        txn_cnt_d = txn_base;
        if (accept) begin
            if (txn_base != CNT_MAX) begin
                txn_cnt_d = txn_base + CNT_W'(1);
            end
            if (mismatch && (err_base != CNT_MAX)) begin
                err_cnt_d = err_base + CNT_W'(1);
            end
            if (err_cnt_d >= THRESH) begin
                health_d = FAILED;
            end else if (mismatch && (health_d == OK)) begin
                health_d = DEGRADED;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_q <= '0;
            txn_cnt_q <= '0;
            health_q  <= OK;
        end else begin
            err_cnt_q <= err_cnt_d;
            txn_cnt_q <= txn_cnt_d;
            health_q  <= health_d;
        end
    end

    addr4u_skid2 u_skid (
        .clk        (clk),
        .rst        (rst),
        .push_valid (in_valid),
        .push_ready (in_ready),
        .push_data  (entry),
        .pop_valid  (out_valid),
        .pop_ready  (out_ready),
        .pop_data   (head)
    );

    assign out_sum = head.sum;
    assign out_err = head.err;
    assign err_cnt = err_cnt_q;
    assign txn_cnt = txn_cnt_q;
    assign health  = health_q;

endmodule

// File: tb/tb_addr4u_result_checker.sv
// Directed bench for addr4u_result_checker: three configurations share one stimulus
// stream and are compared every cycle against a queue-based reference model.
`timescale 1ns/1ps
module tb_addr4u_result_checker;
    import addr4u_pkg::*;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [4:0] s;
    } beat_t;

    localparam int THR = 4;

    logic       clk = 1'b0;
    logic       rst, in_valid, out_ready, clr_stats;
    logic [3:0] in_a, in_b;
    logic [4:0] in_sum;

    logic       r0, v0, e0, r1, v1, e1, r2, v2, e2;
    logic [4:0] s0, s1, s2;
    logic [7:0] ec0, tc0, ec1, tc1;
    logic [2:0] ec2, tc2;
    logic [1:0] h0, h1, h2;

    beat_t q[$];
    int    m_err[3];
    int    m_txn[3];
    int    m_hl[3];
    int    cmax[3] = '{255, 255, 7};
    bit    ce[3]   = '{1'b1, 1'b0, 1'b1};
    bit    chk_en  = 1'b0;
    int    n_vec   = 0;
    int    n_mis   = 0;
    bit    acc;

    always #5 clk = ~clk;

    addr4u_result_checker #(.CNT_W(8), .FAIL_THRESH(4), .CORRECT_EN(1'b1)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r0), .in_a(in_a), .in_b(in_b),
        .in_sum(in_sum), .out_valid(v0), .out_ready(out_ready), .out_sum(s0), .out_err(e0),
        .err_cnt(ec0), .txn_cnt(tc0), .health(h0), .clr_stats(clr_stats));

    addr4u_result_checker #(.CNT_W(8), .FAIL_THRESH(4), .CORRECT_EN(1'b0)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r1), .in_a(in_a), .in_b(in_b),
        .in_sum(in_sum), .out_valid(v1), .out_ready(out_ready), .out_sum(s1), .out_err(e1),
        .err_cnt(ec1), .txn_cnt(tc1), .health(h1), .clr_stats(clr_stats));

    addr4u_result_checker #(.CNT_W(3), .FAIL_THRESH(4), .CORRECT_EN(1'b1)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r2), .in_a(in_a), .in_b(in_b),
        .in_sum(in_sum), .out_valid(v2), .out_ready(out_ready), .out_sum(s2), .out_err(e2),
        .err_cnt(ec2), .txn_cnt(tc2), .health(h2), .clr_stats(clr_stats));

    function automatic int golden_of(input beat_t bt);
        return int'(bt.a) + int'(bt.b);
    endfunction

    function automatic int exp_sum(input beat_t bt, input bit c);
        if (c && (int'(bt.s) != golden_of(bt))) return golden_of(bt);
        return int'(bt.s);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input int exp);
        n_vec++;
        if (act !== 32'(exp)) begin
            n_mis++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_inst(input int i, input logic rdy, input logic vld,
                            input logic [4:0] sm, input logic er,
                            input logic [7:0] ec, input logic [7:0] tc, input logic [1:0] h);
        chk($sformatf("in_ready[%0d]", i), 32'(rdy), int'(q.size() < 2));
        chk($sformatf("out_valid[%0d]", i), 32'(vld), int'(q.size() > 0));
        if (q.size() > 0) begin
            chk($sformatf("out_sum[%0d]", i), 32'(sm), exp_sum(q[0], ce[i]));
            chk($sformatf("out_err[%0d]", i), 32'(er), int'(int'(q[0].s) != golden_of(q[0])));
        end
        chk($sformatf("err_cnt[%0d]", i), 32'(ec), m_err[i]);
        chk($sformatf("txn_cnt[%0d]", i), 32'(tc), m_txn[i]);
        chk($sformatf("health[%0d]", i), 32'(h), m_hl[i]);
    endtask

    // Per-cycle comparison of all three instances against the model.
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            chk_inst(0, r0, v0, s0, e0, ec0, tc0, h0);
            chk_inst(1, r1, v1, s1, e1, ec1, tc1, h1);
            chk_inst(2, r2, v2, s2, e2, {5'd0, ec2}, {5'd0, tc2}, h2);
        end
    end

    // Drive one cycle of inputs, advance the model across the edge, return #1 after it.
    task automatic cycle(input bit v, input logic [3:0] a, input logic [3:0] b,
                         input logic [4:0] s, input bit ordy, input bit clr, input bit r,
                         output bit accepted);
        beat_t bt;
        bit    mm;
        rst       = r;
        in_valid  = v;
        out_ready = ordy;
        clr_stats = clr;
        if (v) begin
            in_a = a; in_b = b; in_sum = s;
        end else begin
            in_a = 4'($urandom()); in_b = 4'($urandom()); in_sum = 5'($urandom());
        end
        bt       = '{a, b, s};
        mm       = (int'(s) != golden_of(bt));
        accepted = v && !r && (q.size() < 2);
        @(posedge clk);
        if (r) begin
            q.delete();
            for (int i = 0; i < 3; i++) begin
                m_err[i] = 0; m_txn[i] = 0; m_hl[i] = 0;
            end
        end else begin
            if ((q.size() > 0) && ordy) void'(q.pop_front());
            if (accepted) q.push_back(bt);
            for (int i = 0; i < 3; i++) begin
                if (clr) begin
                    m_err[i] = 0; m_txn[i] = 0; m_hl[i] = 0;
                end
                if (accepted) begin
                    if (m_txn[i] < cmax[i]) m_txn[i]++;
                    if (mm && (m_err[i] < cmax[i])) m_err[i]++;
                    if (m_err[i] >= THR) m_hl[i] = 2;
                    else if (mm && (m_hl[i] == 0)) m_hl[i] = 1;
                end
            end
        end
        #1;
    endtask

    task automatic idle(input bit ordy);
        bit dummy;
        cycle(1'b0, 4'h0, 4'h0, 5'h00, ordy, 1'b0, 1'b0, dummy);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            m_err[i] = 0; m_txn[i] = 0; m_hl[i] = 0;
        end
        cycle(1'b0, 4'h0, 4'h0, 5'h00, 1'b1, 1'b0, 1'b1, acc);
        cycle(1'b0, 4'h0, 4'h0, 5'h00, 1'b1, 1'b0, 1'b1, acc);
        chk_en = 1'b1;
        chk("lit_rst_in_ready", 32'(r0), 1);
        chk("lit_rst_out_valid", 32'(v0), 0);
        chk("lit_rst_out_sum", 32'(s0), 0);
        chk("lit_rst_out_err", 32'(e0), 0);
        chk("lit_rst_health", 32'(h0), 0);

        // Clean beat with carry out.
        cycle(1'b1, 4'hF, 4'h1, 5'h10, 1'b1, 1'b0, 1'b0, acc);
        chk("lit_clean_valid", 32'(v0), 1);
        chk("lit_clean_sum", 32'(s0), 5'h10);
        chk("lit_clean_err", 32'(e0), 0);
        chk("lit_clean_txn", 32'(tc0), 1);
        chk("lit_clean_health", 32'(h0), 0);
        idle(1'b1);

        // Faulty beat: corrected on dut0, forwarded raw on dut1.
        cycle(1'b1, 4'h9, 4'h8, 5'h01, 1'b1, 1'b0, 1'b0, acc);
        chk("lit_fault_sum_corr", 32'(s0), 5'h11);
        chk("lit_fault_err", 32'(e0), 1);
        chk("lit_fault_errcnt", 32'(ec0), 1);
        chk("lit_fault_health", 32'(h0), 1);
        chk("lit_fault_sum_raw", 32'(s1), 5'h01);
        idle(1'b1);

        // Clear, then four faults reach the threshold.
        cycle(1'b0, 4'h0, 4'h0, 5'h00, 1'b1, 1'b1, 1'b0, acc);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 4'(i + 3), 4'h4, 5'h00, 1'b1, 1'b0, 1'b0, acc);
            if (i == 2) chk("lit_3rd_fault_degraded", 32'(h0), 1);
        end
        chk("lit_4th_fault_failed", 32'(h0), 2);
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 4'(i), 4'(9 - i), 5'h09, 1'b1, 1'b0, 1'b0, acc);
        end
        chk("lit_failed_sticky", 32'(h0), 2);
        chk("lit_txn_14", 32'(tc0), 14);
        cycle(1'b0, 4'h0, 4'h0, 5'h00, 1'b1, 1'b1, 1'b0, acc);
        chk("lit_clr_err", 32'(ec0), 0);
        chk("lit_clr_txn", 32'(tc0), 0);
        chk("lit_clr_health", 32'(h0), 0);
        idle(1'b1);

        // Backpressure: two beats fill the buffer, the third is held.
        cycle(1'b1, 4'h1, 4'h2, 5'h03, 1'b0, 1'b0, 1'b0, acc);
        cycle(1'b1, 4'h4, 4'h5, 5'h09, 1'b0, 1'b0, 1'b0, acc);
        chk("lit_bp_full", 32'(r0), 0);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 4'h6, 4'h7, 5'h0D, 1'b0, 1'b0, 1'b0, acc);
            chk("lit_bp_hold_sum", 32'(s0), 5'h03);
            chk("lit_bp_hold_ready", 32'(r0), 0);
        end
        cycle(1'b1, 4'h6, 4'h7, 5'h0D, 1'b1, 1'b0, 1'b0, acc);
        chk("lit_bp_second_head", 32'(s0), 5'h09);
        for (int t = 0; (t < 4) && !acc; t++) begin
            cycle(1'b1, 4'h6, 4'h7, 5'h0D, 1'b1, 1'b0, 1'b0, acc);
        end
        chk("lit_bp_third_head", 32'(s0), 5'h0D);
        chk("lit_bp_txn", 32'(tc0), 3);
        for (int i = 0; i < 3; i++) idle(1'b1);

        // Reset with two entries buffered.
        cycle(1'b1, 4'h2, 4'h2, 5'h04, 1'b0, 1'b0, 1'b0, acc);
        cycle(1'b1, 4'h3, 4'h3, 5'h07, 1'b0, 1'b0, 1'b0, acc);
        cycle(1'b0, 4'h0, 4'h0, 5'h00, 1'b0, 1'b0, 1'b1, acc);
        chk("lit_midrst_valid", 32'(v0), 0);
        chk("lit_midrst_ready", 32'(r0), 1);
        chk("lit_midrst_err", 32'(ec0), 0);
        chk("lit_midrst_txn", 32'(tc0), 0);

        // Saturation on the 3-bit instance.
        for (int i = 0; i < 9; i++) begin
            cycle(1'b1, 4'h5, 4'h5, 5'h00, 1'b1, 1'b0, 1'b0, acc);
        end
        chk("lit_sat_err", 32'(ec2), 7);
        chk("lit_sat_txn", 32'(tc2), 7);
        chk("lit_sat_health", 32'(h2), 2);
        chk("lit_nosat_err", 32'(ec0), 9);

        // Accept coinciding with clr_stats counts that beat alone.
        cycle(1'b1, 4'h9, 4'h8, 5'h01, 1'b1, 1'b1, 1'b0, acc);
        chk("lit_clracc_err", 32'(ec0), 1);
        chk("lit_clracc_txn", 32'(tc0), 1);
        chk("lit_clracc_health", 32'(h0), 1);
        for (int i = 0; i < 3; i++) idle(1'b1);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
